// File: rtl/bike_pkg.sv
// Shared wheel-size constants, FSM state type and a BCD digit helper.
// Pure declarations; no clocked logic lives here.
package bike_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [8:0]  WHEEL_DEFAULT_CM  = 9'd213;
  localparam logic [8:0]  WHEEL_MIN_CM      = 9'd100;
  localparam logic [8:0]  WHEEL_MAX_CM      = 9'd299;
  localparam logic [11:0] WHEEL_DEFAULT_BCD = 12'h213;

  // Single BCD digit increment that wraps 9 -> 0 without producing a carry.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/wheelsize_bcd2bin.sv
// Combinational 3-digit BCD to binary converter, zero latency.
// Output is 10 bits so that any edited value up to 999 can be range-checked.
module wheelsize_bcd2bin (
  input  logic [11:0] i_bcd,
  output logic [9:0]  o_bin
);

  logic [9:0] w_hund;
  logic [9:0] w_tens;
  logic [9:0] w_unit;

  assign w_hund = {6'd0, i_bcd[11:8]};
  assign w_tens = {6'd0, i_bcd[7:4]};
  assign w_unit = {6'd0, i_bcd[3:0]};
  assign o_bin  = (w_hund * 10'd100) + (w_tens * 10'd10) + w_unit;

endmodule

// File: rtl/wheelsize_config.sv
// Wheel circumference menu editor: per-digit BCD edit, range-checked commit.
// Status pulses one cycle after COMMIT; wheelsize_bin trails wheelsize_bcd by one cycle.
module wheelsize_config
  import bike_pkg::*;
(
  input  logic        Clock,
  input  logic        nReset,
  input  logic        wheelsize_menu,
  input  logic        wheelsize_digit_change,
  input  logic        wheelsize_value_change,
  output logic [11:0] edit_bcd,
  output logic [1:0]  digit_sel,
  output logic [11:0] wheelsize_bcd,
  output logic [8:0]  wheelsize_bin,
  output logic        commit_ok,
  output logic        range_err
);

  state_t      r_state;
  logic        r_menu_d;
  logic [11:0] r_edit_bcd;
  logic [1:0]  r_digit_sel;
  logic [11:0] r_wheelsize_bcd;
  logic [8:0]  r_wheelsize_bin;
  logic        r_commit_ok;
  logic        r_range_err;

  logic        w_rise;
  logic        w_fall;
  logic [11:0] w_edit_next;
  logic [1:0]  w_sel_next;
  logic [11:0] w_conv_in;
  logic [9:0]  w_conv_bin;
  logic        w_in_range;

  assign w_rise = wheelsize_menu & ~r_menu_d;
  assign w_fall = ~wheelsize_menu & r_menu_d;

  // One converter serves both paths: the edit value during COMMIT, the committed value otherwise.
  assign w_conv_in  = (r_state == COMMIT) ? r_edit_bcd : r_wheelsize_bcd;
  assign w_in_range = (w_conv_bin >= {1'b0, WHEEL_MIN_CM}) && (w_conv_bin <= {1'b0, WHEEL_MAX_CM});

  wheelsize_bcd2bin u_bcd2bin (
    .i_bcd (w_conv_in),
    .o_bin (w_conv_bin)
  );

  always_comb begin
    w_edit_next = r_edit_bcd;
    w_sel_next  = r_digit_sel;
    if (wheelsize_value_change) begin
      case (r_digit_sel)
        2'd2:    w_edit_next[11:8] = bcd_inc(r_edit_bcd[11:8]);
        2'd1:    w_edit_next[7:4]  = bcd_inc(r_edit_bcd[7:4]);
        default: w_edit_next[3:0]  = bcd_inc(r_edit_bcd[3:0]);
      endcase
    end
    if (wheelsize_digit_change) begin
      w_sel_next = (r_digit_sel == 2'd0) ? 2'd2 : r_digit_sel - 2'd1;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state         <= IDLE;
      r_menu_d        <= 1'b0;
      r_edit_bcd      <= WHEEL_DEFAULT_BCD;
      r_digit_sel     <= 2'd2;
      r_wheelsize_bcd <= WHEEL_DEFAULT_BCD;
      r_wheelsize_bin <= WHEEL_DEFAULT_CM;
      r_commit_ok     <= 1'b0;
      r_range_err     <= 1'b0;
    end else begin
      r_menu_d    <= wheelsize_menu;
      r_commit_ok <= 1'b0;
      r_range_err <= 1'b0;
      if (r_state != COMMIT) begin
        r_wheelsize_bin <= w_conv_bin[8:0];
      end
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state     <= EDIT;
            r_edit_bcd  <= r_wheelsize_bcd;
            r_digit_sel <= 2'd2;
          end
        end
        EDIT: begin
          r_edit_bcd  <= w_edit_next;
          r_digit_sel <= w_sel_next;
          if (w_fall) begin
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
          r_commit_ok <= w_in_range;
          r_range_err <= ~w_in_range;
          if (w_in_range) begin
            r_wheelsize_bcd <= r_edit_bcd;
          end
          // A re-open in this cycle reloads from the value the commit is about to leave behind.
          if (w_rise) begin
            r_state     <= EDIT;
            r_edit_bcd  <= w_in_range ? r_edit_bcd : r_wheelsize_bcd;
            r_digit_sel <= 2'd2;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign edit_bcd      = r_edit_bcd;
  assign digit_sel     = r_digit_sel;
  assign wheelsize_bcd = r_wheelsize_bcd;
  assign wheelsize_bin = r_wheelsize_bin;
  assign commit_ok     = r_commit_ok;
  assign range_err     = r_range_err;

endmodule

// File: tb/tb_wheelsize_config.sv
// Self-checking bench: decimal-digit reference model compared every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_wheelsize_config;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        menu = 1'b0;
  logic        dchg = 1'b0;
  logic        vchg = 1'b0;
  logic [11:0] edit_bcd;
  logic [1:0]  digit_sel;
  logic [11:0] wheelsize_bcd;
  logic [8:0]  wheelsize_bin;
  logic        commit_ok;
  logic        range_err;

  int checks = 0;
  int errors = 0;

  wheelsize_config dut (
    .Clock                  (Clock),
    .nReset                 (nReset),
    .wheelsize_menu         (menu),
    .wheelsize_digit_change (dchg),
    .wheelsize_value_change (vchg),
    .edit_bcd               (edit_bcd),
    .digit_sel              (digit_sel),
    .wheelsize_bcd          (wheelsize_bcd),
    .wheelsize_bin          (wheelsize_bin),
    .commit_ok              (commit_ok),
    .range_err              (range_err)
  );

  always #5 Clock = ~Clock;

  // Reference model: digits as decimal integers, committed size in plain centimetres.
  int m_dig[3] = '{3, 1, 2};
  int m_sel = 2;
  int m_wheel = 213;
  int m_bin = 213;
  bit m_prev = 0, m_editing = 0, m_pending = 0, m_ok = 0, m_err = 0;
  bit m_rise, m_fall;
  int m_v;

  function automatic int digits_value();
    return m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
  endfunction

  function automatic int to_bcd(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic model_open();
    m_editing = 1;
    m_dig[2] = m_wheel / 100;
    m_dig[1] = (m_wheel / 10) % 10;
    m_dig[0] = m_wheel % 10;
    m_sel = 2;
  endtask

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      m_dig[2] = 2; m_dig[1] = 1; m_dig[0] = 3;
      m_sel = 2; m_wheel = 213; m_bin = 213;
      m_prev = 0; m_editing = 0; m_pending = 0; m_ok = 0; m_err = 0;
    end else begin
      m_rise = menu && !m_prev;
      m_fall = !menu && m_prev;
      m_ok = 0;
      m_err = 0;
      m_bin = m_wheel;
      if (m_pending) begin
        m_pending = 0;
        m_v = digits_value();
        if (m_v >= 100 && m_v <= 299) begin
          m_wheel = m_v;
          m_ok = 1;
        end else begin
          m_err = 1;
        end
        if (m_rise) model_open();
      end else if (m_editing) begin
        if (vchg) m_dig[m_sel] = (m_dig[m_sel] + 1) % 10;
        if (dchg) m_sel = (m_sel + 2) % 3;
        if (m_fall) begin
          m_editing = 0;
          m_pending = 1;
        end
      end else if (m_rise) begin
        model_open();
      end
      m_prev = menu;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cmp_all();
    chk("edit_bcd", int'(edit_bcd), digits_value() == 0 ? 0 : to_bcd(digits_value()));
    chk("digit_sel", int'(digit_sel), m_sel);
    chk("wheelsize_bcd", int'(wheelsize_bcd), to_bcd(m_wheel));
    chk("wheelsize_bin", int'(wheelsize_bin), m_bin);
    chk("commit_ok", int'(commit_ok), int'(m_ok));
    chk("range_err", int'(range_err), int'(m_err));
    chk("pulse_exclusive", int'(commit_ok & range_err), 0);
  endtask

  task automatic step(input bit m, input bit d, input bit v);
    @(negedge Clock);
    cmp_all();
    menu = m;
    dchg = d;
    vchg = v;
  endtask

  initial begin
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("lit_reset_wbcd", int'(wheelsize_bcd), 'h213);
    chk("lit_reset_bin", int'(wheelsize_bin), 213);
    chk("lit_reset_sel", int'(digit_sel), 2);
    chk("lit_reset_ok", int'(commit_ok), 0);
    chk("lit_reset_err", int'(range_err), 0);
    chk("lit_model_default", m_wheel, 213);

    // Hundreds 2->3 gives 313: out of range.
    step(1, 0, 0); step(1, 0, 1); step(1, 0, 0);
    chk("lit_edit_313", int'(edit_bcd), 'h313);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("lit_err_313", int'(range_err), 1);
    chk("lit_keep_213", int'(wheelsize_bcd), 'h213);
    step(0, 0, 0);
    chk("lit_err_one_cycle", int'(range_err), 0);

    // v x1, d x1, v x2, d x1, v x1 from 213 lands on 334: rejected.
    step(1, 0, 0); step(1, 0, 1); step(1, 1, 0); step(1, 0, 1); step(1, 0, 1);
    step(1, 1, 0); step(1, 0, 1); step(1, 0, 0);
    chk("lit_edit_334", int'(edit_bcd), 'h334);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("lit_err_334", int'(range_err), 1);
    chk("lit_keep_213b", int'(wheelsize_bcd), 'h213);

    // Skip hundreds, tens 1->3, units 3->4: 234 accepted.
    step(1, 0, 0); step(1, 1, 0); step(1, 0, 1); step(1, 0, 1); step(1, 1, 0);
    step(1, 0, 1); step(1, 0, 0);
    chk("lit_edit_234", int'(edit_bcd), 'h234);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("lit_ok_234", int'(commit_ok), 1);
    chk("lit_wbcd_234", int'(wheelsize_bcd), 'h234);
    chk("lit_bin_lag", int'(wheelsize_bin), 213);
    step(0, 0, 0);
    chk("lit_bin_234", int'(wheelsize_bin), 234);
    chk("lit_ok_one_cycle", int'(commit_ok), 0);

    // Units wrap 9->0 without carry, then a full digit rotation.
    step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
    repeat (5) step(1, 0, 1);
    step(1, 0, 0);
    chk("lit_edit_239", int'(edit_bcd), 'h239);
    step(1, 0, 1); step(1, 0, 0);
    chk("lit_wrap_230", int'(edit_bcd), 'h230);
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    chk("lit_rotate_sel0", int'(digit_sel), 0);

    // Simultaneous pulses on tens: increment first, then advance.
    step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    chk("lit_sel1", int'(digit_sel), 1);
    step(1, 1, 1); step(1, 0, 0);
    chk("lit_simul_240", int'(edit_bcd), 'h240);
    chk("lit_simul_sel0", int'(digit_sel), 0);

    // Close then re-open right away; pulses during COMMIT are ignored.
    step(0, 0, 0); step(1, 1, 1); step(1, 0, 0);
    chk("lit_reopen_ok", int'(commit_ok), 1);
    chk("lit_reopen_wbcd", int'(wheelsize_bcd), 'h240);
    chk("lit_reopen_edit", int'(edit_bcd), 'h240);
    chk("lit_reopen_sel", int'(digit_sel), 2);

    // Reset in the middle of an edit.
    step(1, 0, 1); step(1, 0, 0);
    #2 nReset = 1'b0;
    #1;
    chk("lit_arst_edit", int'(edit_bcd), 'h213);
    chk("lit_arst_wbcd", int'(wheelsize_bcd), 'h213);
    chk("lit_arst_bin", int'(wheelsize_bin), 213);
    chk("lit_arst_sel", int'(digit_sel), 2);
    step(0, 0, 0); step(0, 0, 0);
    nReset = 1'b1;
    step(0, 1, 1); step(0, 1, 1); step(0, 1, 1); step(0, 0, 0);
    chk("lit_idle_ignore_edit", int'(edit_bcd), 'h213);
    chk("lit_idle_ignore_sel", int'(digit_sel), 2);

    // Randomized sessions against the model.
    begin
      bit rm;
      rm = 0;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 9) == 0) rm = !rm;
        step(rm, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      end
    end
    repeat (4) step(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
